// File: rtl/crc32_frame_appender_if.sv
// Valid/ready/last word stream used on both sides of the CRC framer.
//   data  : 32-bit word
//   valid : word valid
//   last  : frame delimiter (meaning depends on side, see crc32_frame_appender)
//   ready : sink accepts this cycle
// master drives data/valid/last and samples ready; slave is the mirror image.
interface crc32_frame_appender_if;
   logic [31:0] data;
   logic        valid;
   logic        last;
   logic        ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/crc32_frame_appender.sv
// Streaming CRC-32 framer. Forwards payload words unchanged, keeps a running
// MSB-first CRC-32 and appends it as one extra word (m_last=1) after the last
// payload word of each frame. Also publishes the final CRC and payload word
// count of the most recently completed frame.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   s_if        : payload input stream (slave); last marks final payload word
//   m_if        : output stream (master); last marks the appended CRC word
//   crc_out     : CRC of most recently completed frame
//   crc_done    : one-cycle pulse when crc_out updates
//   word_count  : payload words in most recently completed frame (saturating)
//
// Build option: CRC_INIT_ONES_EN -- seed the CRC with all ones and invert the
// final value. Without it the seed is zero with no inversion, which makes a
// one-word frame hash identically to the single-word crc block.
//
// state  | meaning
// -------+---------------------------------------------------------------
// PASS   | forwarding payload words, accumulating CRC and word count
// APPEND | last payload word taken; emit CRC word when output slot frees
module crc32_frame_appender #(
   parameter logic [31:0] POLY  = 32'h04C11DB7,
   parameter int          CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   crc32_frame_appender_if.slave    s_if,
   crc32_frame_appender_if.master   m_if,
   output logic [31:0]              crc_out,
   output logic                     crc_done,
   output logic [CNT_W-1:0]         word_count
);

`ifdef CRC_INIT_ONES_EN
   localparam logic [31:0] INIT      = 32'hFFFF_FFFF;
   localparam logic [31:0] FINAL_XOR = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] INIT      = 32'h0000_0000;
   localparam logic [31:0] FINAL_XOR = 32'h0000_0000;
`endif

   typedef enum logic {ST_PASS, ST_APPEND} state_t;

   // x * 2^32 mod P: a full word shifted through the LFSR in one cycle
   function automatic logic [31:0] f_step(input logic [31:0] x);
      logic [31:0] v;
      v = x;
      for (int i = 0; i < 32; i++) begin
         v = v[31] ? ((v << 1) ^ POLY) : (v << 1);
      end
      return v;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [31:0]        r_crc;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_m_data;
   logic               r_m_valid;
   logic               r_m_last;
   logic [31:0]        r_crc_out;
   logic               r_crc_done;
   logic [CNT_W-1:0]   r_word_count;

   logic               w_slot_free;
   logic               w_s_ready;
   logic               w_load_pay;
   logic               w_load_crc;
   logic [31:0]        w_crc_next;
   logic [31:0]        w_crc_final;

   assign w_slot_free = !r_m_valid || m_if.ready;
   assign w_crc_next  = f_step(r_crc ^ s_if.data);
   assign w_crc_final = r_crc ^ FINAL_XOR;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_PASS;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_s_ready   = 1'b0;
      w_load_pay  = 1'b0;
      w_load_crc  = 1'b0;
      case (r_state)
         ST_PASS: begin
            w_s_ready = w_slot_free;
            if (s_if.valid && w_slot_free) begin
               w_load_pay = 1'b1;
               if (s_if.last) begin
                  w_state_nxt = ST_APPEND;
               end
            end
         end
         ST_APPEND: begin
            if (w_slot_free) begin
               w_load_crc  = 1'b1;
               w_state_nxt = ST_PASS;
            end
         end
         default: w_state_nxt = ST_PASS;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_crc        <= INIT;
         r_cnt        <= '0;
         r_m_data     <= '0;
         r_m_valid    <= 1'b0;
         r_m_last     <= 1'b0;
         r_crc_out    <= '0;
         r_crc_done   <= 1'b0;
         r_word_count <= '0;
      end else begin
         r_crc_done <= w_load_crc;
         if (w_load_pay) begin
            r_m_data  <= s_if.data;
            r_m_valid <= 1'b1;
            r_m_last  <= 1'b0;
            r_crc     <= w_crc_next;
            if (!(&r_cnt)) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else if (w_load_crc) begin
            r_m_data     <= w_crc_final;
            r_m_valid    <= 1'b1;
            r_m_last     <= 1'b1;
            r_crc_out    <= w_crc_final;
            r_word_count <= r_cnt;
            r_crc        <= INIT;
            r_cnt        <= '0;
         end else if (r_m_valid && m_if.ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
         end
      end
   end

   assign s_if.ready = w_s_ready;
   assign m_if.data  = r_m_data;
   assign m_if.valid = r_m_valid;
   assign m_if.last  = r_m_last;
   assign crc_out    = r_crc_out;
   assign crc_done   = r_crc_done;
   assign word_count = r_word_count;

endmodule

// File: doc/crc32_frame_appender.md
# crc32_frame_appender

Streaming CRC-32 framer downstream of the word packer and upstream of the link transmitter. Accepts 32-bit words with valid/ready/last framing, forwards each word unchanged, accumulates a running CRC-32 (MSB-first, same polynomial and bit ordering as our single-word `crc` block), and appends the CRC as one extra word after the last word of each frame. Also reports the final CRC and the frame's payload word count to the status logic.

## Interface
- `POLY`, 32'h04C11DB7: generator polynomial without the x^32 term.
- `CNT_W`, 16: width of the payload word counter.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_data`  in  32  input payload word.
- `s_valid`  in  1  input word valid.
- `s_last`  in  1  marks last payload word of frame; qualified by `s_valid`.
- `s_ready`  out  1  block accepts input this cycle.
- `m_data`  out  32  output word: payload or appended CRC.
- `m_valid`  out  1  output word valid.
- `m_last`  out  1  high only on the appended CRC word.
- `m_ready`  in  1  downstream accepts output this cycle.
- `crc_out`  out  32  CRC of most recently completed frame.
- `crc_done`  out  1  one-cycle pulse when `crc_out` updates.
- `word_count`  out  CNT_W  payload words of most recently completed frame.

## Operation
- Step function F(x): 32 iterations of: if bit31 set, x = (x<<1) ^ POLY, else x = x<<1. Equivalent to x·2^32 mod P.
- Running CRC register `crc`, init value INIT (32'h0 by default). On each accepted payload word: crc <= F(crc ^ s_data). A one-word frame from INIT 0 yields the same value as the `crc` block's hash for that word.
- States: PASS, APPEND.
- PASS: `s_ready` = !m_valid || m_ready. On accept (s_valid && s_ready): m_data <= s_data, m_valid <= 1, m_last <= 0, crc updated, counter incremented (saturating at all-ones). If s_last, go to APPEND.
- APPEND: `s_ready` = 0. When !m_valid || m_ready: m_data <= final CRC, m_valid <= 1, m_last <= 1, crc_out <= final CRC, word_count <= counter, crc_done pulse, crc <= INIT, counter <= 0, go to PASS.
- Output register cleared (m_valid <= 0) when m_ready && m_valid and nothing new is loaded.
- Empty frames are impossible: `s_last` always accompanies a payload word.
- Output stable while m_valid && !m_ready (no data change, no valid drop).

## Timing
- Reset: state PASS, crc = INIT, counter = 0, m_data = 0, m_valid = 0, m_last = 0, crc_out = 0, word_count = 0, crc_done = 0. `s_ready` is 1 the first cycle after reset release.
- Latency: accepted word appears on `m_data` the next cycle.
- Throughput with m_ready held high: N-word frame consumes N+1 cycles; `s_ready` low exactly one cycle (APPEND).
- CRC word appears on output the cycle after the last-word output handshake slot frees; `crc_done` asserts in the same cycle the CRC word is loaded into the output register.
- Back-to-back frames: first word of next frame accepted the cycle after the CRC word is loaded, if slot free.
- Reset asserted mid-frame: partial frame discarded, all registers to reset values immediately; no CRC word emitted.
- F computed combinationally in one cycle; no multicycle paths.

## Configuration
- `CRC_INIT_ONES_EN`: defined -> INIT = 32'hFFFFFFFF and final CRC (appended word, `crc_out`) = crc ^ 32'hFFFFFFFF. Undefined -> INIT = 0, no final inversion (matches the single-word `crc` block).

## Test plan
- Single-word frame 0x00000001, m_ready=1 -> output 0x00000001 (m_last=0), then 0x04C11DB7 (m_last=1), crc_done pulse, crc_out=0x04C11DB7, word_count=1.
- Frame {0x00000001, 0x04C11DB7} -> appended CRC 0x00000000, word_count=2 (residue check).
- Frame {0x00000000, 0x00000001} back-to-back with frame {0x00000001}, m_ready=1, s_valid continuous -> CRCs 0x04C11DB7 and 0x04C11DB7; s_ready low exactly one cycle per frame; 5 output words in 5 consecutive cycles after first.
- Random m_ready stalls over 8-word frame -> output data/last never change while stalled, no words lost or duplicated, CRC equals unstalled run.
- rst pulse after 3 words of 6-word frame -> all outputs reset values, no CRC word; subsequent 0x00000001 frame yields 0x04C11DB7.
- With `CRC_INIT_ONES_EN`: frame {0xFFFFFFFF} -> appended CRC 0xFFFFFFFF.
